// File: rtl/clause_literal_builder.sv
// clause_literal_builder: CNF clause table that evaluates every literal against an assignment
module clause_literal_builder #(
    parameter int NUM_CLAUSES         = 16,
    parameter int NUM_VARS_PER_CLAUSE = 3,
    parameter int NUM_VARS            = 16,
    parameter int VAR_IDX_W           = $clog2(NUM_VARS)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           clear,
    input  logic                                           load_valid,
    output logic                                           load_ready,
    input  logic [NUM_VARS_PER_CLAUSE*(VAR_IDX_W+1)-1:0]   load_lits,
    output logic [$clog2(NUM_CLAUSES+1)-1:0]               clause_count,
    input  logic                                           eval_valid,
    input  logic [NUM_VARS-1:0]                            assignment,
    output logic [NUM_CLAUSES*NUM_VARS_PER_CLAUSE-1:0]     clauses_out,
    output logic                                           clauses_valid
);
    localparam int V  = NUM_VARS_PER_CLAUSE;
    localparam int LW = VAR_IDX_W + 1;
    localparam int CW = $clog2(NUM_CLAUSES + 1);
    localparam int SW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam int OW = NUM_CLAUSES * V;

    typedef enum logic [1:0] {EMPTY, LOADING, FULL} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [V*LW-1:0]    tbl_q [NUM_CLAUSES];
    logic [V*LW-1:0]    tbl_d [NUM_CLAUSES];
    logic [OW-1:0]      out_q, out_d, eval_w;
    logic               valid_q, valid_d;

    // Slots at or above the count are unloaded and read as all-true (0)
    for (genvar k = 0; k < NUM_CLAUSES; k++) begin : g_slot
        for (genvar j = 0; j < V; j++) begin : g_lit
            logic [LW-1:0] lit;
            assign lit = tbl_q[k][(V-1-j)*LW +: LW];
            assign eval_w[OW-1-k*V-j] = (CW'(k) < count_q) &&
                ((int'(lit[VAR_IDX_W-1:0]) >= NUM_VARS) || !(assignment[lit[VAR_IDX_W-1:0]] ^ lit[VAR_IDX_W]));
        end
    end

    assign load_ready    = (state_q != FULL);
    assign clause_count  = count_q;
    assign clauses_out   = out_q;
    assign clauses_valid = valid_q;

    // Next state: clear wins; evaluation sees the table before this edge's load
    always_comb begin
        count_d = count_q;
        tbl_d   = tbl_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else begin
            if (load_valid && load_ready) begin
                tbl_d[count_q[SW-1:0]] = load_lits;
                count_d = count_q + CW'(1);
            end
            if (eval_valid) begin
                out_d   = eval_w;
                valid_d = 1'b1;
            end
        end
        state_d = (count_d == '0) ? EMPTY : (count_d == CW'(NUM_CLAUSES)) ? FULL : LOADING;
    end

    // Table, count, FSM state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            tbl_q   <= '{default: '0};
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tbl_q   <= tbl_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end
endmodule
